// File: rtl/ft_pkg.sv
// Shared definitions for the register-file restore path: default widths,
// the restore FSM state encoding and a small sizing helper.
package ft_pkg;

  localparam int FT_ADDR_WIDTH = 5;
  localparam int FT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    DRAIN   = 2'd2
  } restore_state_e;

  function automatic int num_regs(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/regfile_restore_if.sv
// Bundles the commit, replay and core register-file write signals of the
// restore block; the core/controller side is master, the restore block is slave.
interface regfile_restore_if
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FT_DATA_WIDTH
);

  logic                  commit_we_i;
  logic [ADDR_WIDTH-1:0] commit_addr_i;
  logic [DATA_WIDTH-1:0] commit_data_i;
  logic                  replay_active_i;
  logic [ADDR_WIDTH-1:0] replay_addr_i;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_addr_o;
  logic [DATA_WIDTH-1:0] rf_data_o;
  logic                  halt_o;
  logic                  restore_done_o;
  logic [ADDR_WIDTH:0]   restore_count_o;

  modport master (
    output commit_we_i,
    output commit_addr_i,
    output commit_data_i,
    output replay_active_i,
    output replay_addr_i,
    input  rf_we_o,
    input  rf_addr_o,
    input  rf_data_o,
    input  halt_o,
    input  restore_done_o,
    input  restore_count_o
  );

  modport slave (
    input  commit_we_i,
    input  commit_addr_i,
    input  commit_data_i,
    input  replay_active_i,
    input  replay_addr_i,
    output rf_we_o,
    output rf_addr_o,
    output rf_data_o,
    output halt_o,
    output restore_done_o,
    output restore_count_o
  );

endinterface

// File: rtl/checkpoint_rf.sv
// Checkpoint register file: one write port, one registered read port with
// read enable, and a synchronous clear of every entry.
module checkpoint_rf
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_clear,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int NUM_REG = num_regs(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [NUM_REG];
  logic [DATA_WIDTH-1:0] r_rdata;

  // The read register only moves on an enabled read, so the output holds between reads;
  // a same-edge write to the read address is forwarded.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      for (int i = 0; i < NUM_REG; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
        r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/regfile_restore.sv
// Shadows committed writebacks into a checkpoint file and, during a replay sweep,
// streams checkpoint entries back into the core register file one cycle later.
module regfile_restore
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FT_DATA_WIDTH
) (
  input logic              clk,
  input logic              rst_i,
  regfile_restore_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  restore_state_e        r_state;
  restore_state_e        w_next;
  logic                  w_sample;
  logic                  w_read;
  logic                  w_commit;
  logic                  w_halt;
  logic                  w_done_next;
  logic                  w_start;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] w_rdata;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Replay samples are taken on the rising IDLE cycle too, so the first address is not lost.
  always_comb begin
    w_next      = r_state;
    w_sample    = 1'b0;
    w_commit    = 1'b0;
    w_halt      = 1'b0;
    w_done_next = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        w_commit = bus.commit_we_i && (bus.commit_addr_i != '0);
        w_halt   = bus.replay_active_i;
        if (bus.replay_active_i) begin
          w_next   = RESTORE;
          w_sample = 1'b1;
          w_start  = 1'b1;
        end
      end
      RESTORE: begin
        w_halt = 1'b1;
        if (bus.replay_active_i) begin
          w_sample = 1'b1;
        end else begin
          w_next      = DRAIN;
          w_done_next = 1'b1;
        end
      end
      DRAIN: begin
        w_halt = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_read = w_sample && (bus.replay_addr_i != '0);

  checkpoint_rf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_checkpoint (
    .clk    (clk),
    .i_clear(rst_i),
    .i_we   (w_commit),
    .i_waddr(bus.commit_addr_i),
    .i_wdata(bus.commit_data_i),
    .i_re   (w_read),
    .i_raddr(bus.replay_addr_i),
    .o_rdata(w_rdata)
  );

  // The count lags rf_we_o by one edge so that it can clear on the same edge a restore starts.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= w_read;
      r_done <= w_done_next;
      if (w_read) begin
        r_addr <= bus.replay_addr_i;
      end
      if (w_start) begin
        r_count <= '0;
      end else if (r_we && (r_count != COUNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.rf_we_o         = r_we;
  assign bus.rf_addr_o       = r_addr;
  assign bus.rf_data_o       = w_rdata;
  assign bus.halt_o          = w_halt;
  assign bus.restore_done_o  = r_done;
  assign bus.restore_count_o = r_count;

endmodule

// File: tb/tb_regfile_restore.sv
// Directed bench for regfile_restore: each scenario task drives a few cycles
// and compares outputs against hand-computed values.
module tb_regfile_restore;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  regfile_restore_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_restore #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after a rising edge; outputs are read 2 units later.
  task automatic applyStimulus(input logic cWe, input logic [AW-1:0] cAddr, input logic [DW-1:0] cData,
                               input logic act, input logic [AW-1:0] rAddr);
    bus.commit_we_i     = cWe;
    bus.commit_addr_i   = cAddr;
    bus.commit_data_i   = cData;
    bus.replay_active_i = act;
    bus.replay_addr_i   = rAddr;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic commitOne(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, '0);
    nextCycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h1111, 1'b0, 5'd0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.rf_we_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %b expected 0", bus.rf_we_o); end
    vectors++; if (bus.rf_addr_o !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h expected 0", bus.rf_addr_o); end
    vectors++; if (bus.rf_data_o !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 0", bus.rf_data_o); end
    vectors++; if (bus.restore_done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", bus.restore_done_o); end
    vectors++; if (bus.restore_count_o !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.restore_count_o); end
    vectors++; if (bus.halt_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halt: got %b expected 0", bus.halt_o); end
    rst = 1'b0;
    nextCycle();
  endtask

  task automatic test_sweep();
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    logic [AW:0]   expCount;
    commitOne(5'd5, 32'hDEADBEEF);
    commitOne(5'd0, 32'h00001234);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, a[AW-1:0]);
      expWe    = (a >= 2);
      expAddr  = (a >= 2) ? 5'(a - 1) : 5'd0;
      expData  = (a == 6) ? 32'hDEADBEEF : 32'd0;
      expCount = (a >= 2) ? 6'(a - 2) : 6'd0;
      vectors++; if (bus.halt_o !== 1'b1) begin miscompares++; $display("[TB] FAIL sweep_halt[%0d]: got %b expected 1", a, bus.halt_o); end
      vectors++; if (bus.rf_we_o !== expWe) begin miscompares++; $display("[TB] FAIL sweep_we[%0d]: got %b expected %b", a, bus.rf_we_o, expWe); end
      vectors++; if (bus.rf_addr_o !== expAddr) begin miscompares++; $display("[TB] FAIL sweep_addr[%0d]: got %h expected %h", a, bus.rf_addr_o, expAddr); end
      vectors++; if (bus.rf_data_o !== expData) begin miscompares++; $display("[TB] FAIL sweep_data[%0d]: got %h expected %h", a, bus.rf_data_o, expData); end
      vectors++; if (bus.restore_count_o !== expCount) begin miscompares++; $display("[TB] FAIL sweep_count[%0d]: got %0d expected %0d", a, bus.restore_count_o, expCount); end
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd31) begin miscompares++; $display("[TB] FAIL sweep_last: got we=%b addr=%h expected we=1 addr=1f", bus.rf_we_o, bus.rf_addr_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.restore_done_o !== 1'b1) begin miscompares++; $display("[TB] FAIL sweep_done: got %b expected 1", bus.restore_done_o); end
    vectors++; if (bus.restore_count_o !== 6'd31) begin miscompares++; $display("[TB] FAIL sweep_count_final: got %0d expected 31", bus.restore_count_o); end
    vectors++; if (bus.rf_we_o !== 1'b0 || bus.halt_o !== 1'b1) begin miscompares++; $display("[TB] FAIL sweep_drain: got we=%b halt=%b expected we=0 halt=1", bus.rf_we_o, bus.halt_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.restore_done_o !== 1'b0 || bus.halt_o !== 1'b0) begin miscompares++; $display("[TB] FAIL sweep_idle: got done=%b halt=%b expected 0 0", bus.restore_done_o, bus.halt_o); end
  endtask

  task automatic test_short_burst();
    commitOne(5'd7, 32'h77);
    commitOne(5'd8, 32'h88);
    commitOne(5'd9, 32'h99);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    vectors++; if (bus.halt_o !== 1'b1 || bus.rf_we_o !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_c1: got halt=%b we=%b expected 1 0", bus.halt_o, bus.rf_we_o); end
    vectors++; if (bus.restore_count_o !== 6'd31) begin miscompares++; $display("[TB] FAIL burst_c1_count: got %0d expected 31", bus.restore_count_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd7 || bus.rf_data_o !== 32'h77) begin miscompares++; $display("[TB] FAIL burst_c2: got we=%b addr=%h data=%h expected 1 07 77", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o); end
    vectors++; if (bus.restore_count_o !== 6'd0) begin miscompares++; $display("[TB] FAIL burst_c2_count: got %0d expected 0", bus.restore_count_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd8 || bus.rf_data_o !== 32'h88) begin miscompares++; $display("[TB] FAIL burst_c3: got we=%b addr=%h data=%h expected 1 08 88", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd9 || bus.rf_data_o !== 32'h99) begin miscompares++; $display("[TB] FAIL burst_c4: got we=%b addr=%h data=%h expected 1 09 99", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o); end
    vectors++; if (bus.restore_done_o !== 1'b0 || bus.halt_o !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_c4_ctl: got done=%b halt=%b expected 0 1", bus.restore_done_o, bus.halt_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    vectors++; if (bus.restore_done_o !== 1'b1 || bus.rf_we_o !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_c5: got done=%b we=%b expected 1 0", bus.restore_done_o, bus.rf_we_o); end
    vectors++; if (bus.restore_count_o !== 6'd3) begin miscompares++; $display("[TB] FAIL burst_c5_count: got %0d expected 3", bus.restore_count_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.restore_done_o !== 1'b0 || bus.halt_o !== 1'b0 || bus.rf_we_o !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_c6: got done=%b halt=%b we=%b expected 0 0 0", bus.restore_done_o, bus.halt_o, bus.rf_we_o); end
    vectors++; if (bus.rf_addr_o !== 5'd9 || bus.rf_data_o !== 32'h99) begin miscompares++; $display("[TB] FAIL burst_hold: got addr=%h data=%h expected 09 99", bus.rf_addr_o, bus.rf_data_o); end
    nextCycle();
  endtask

  task automatic test_commit_during_restore();
    commitOne(5'd3, 32'h3333);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1);
    nextCycle();
    applyStimulus(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd2);
    nextCycle();
    applyStimulus(1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd3 || bus.rf_data_o !== 32'h3333) begin miscompares++; $display("[TB] FAIL drop_commit: got we=%b addr=%h data=%h expected 1 03 3333", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o); end
    nextCycle();
    nextCycle();
  endtask

  task automatic test_commit_on_rise();
    applyStimulus(1'b1, 5'd4, 32'h55, 1'b1, 5'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd4 || bus.rf_data_o !== 32'h55) begin miscompares++; $display("[TB] FAIL rise_commit: got we=%b addr=%h data=%h expected 1 04 55", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.restore_count_o !== 6'd2 || bus.restore_done_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rise_drain: got count=%0d done=%b expected 2 1", bus.restore_count_o, bus.restore_done_o); end
    nextCycle();
  endtask

  task automatic test_back_to_back_repeat();
    commitOne(5'd6, 32'h66);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd6 || bus.rf_data_o !== 32'h66) begin miscompares++; $display("[TB] FAIL repeat_first: got we=%b addr=%h data=%h expected 1 06 66", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd6 || bus.restore_count_o !== 6'd1) begin miscompares++; $display("[TB] FAIL repeat_second: got we=%b addr=%h count=%0d expected 1 06 1", bus.rf_we_o, bus.rf_addr_o, bus.restore_count_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.restore_count_o !== 6'd2 || bus.restore_done_o !== 1'b1) begin miscompares++; $display("[TB] FAIL repeat_count: got count=%0d done=%b expected 2 1", bus.restore_count_o, bus.restore_done_o); end
    nextCycle();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.restore_count_o !== 6'd32) begin miscompares++; $display("[TB] FAIL saturate_count: got %0d expected 32", bus.restore_count_o); end
    nextCycle();
  endtask

  task automatic test_mid_reset();
    commitOne(5'd10, 32'h1010);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 5'd12, 32'h1212, 1'b1, 5'd11);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd10 || bus.rf_data_o !== 32'h1010) begin miscompares++; $display("[TB] FAIL mid_before: got we=%b addr=%h data=%h expected 1 0a 1010", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o); end
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.rf_we_o !== 1'b0 || bus.halt_o !== 1'b0 || bus.restore_done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_after: got we=%b halt=%b done=%b expected 0 0 0", bus.rf_we_o, bus.halt_o, bus.restore_done_o); end
    vectors++; if (bus.rf_addr_o !== 5'd0 || bus.rf_data_o !== 32'd0 || bus.restore_count_o !== 6'd0) begin miscompares++; $display("[TB] FAIL mid_clear: got addr=%h data=%h count=%0d expected 0 0 0", bus.rf_addr_o, bus.rf_data_o, bus.restore_count_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.restore_done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_nodone: got %b expected 0", bus.restore_done_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd10 || bus.rf_data_o !== 32'd0) begin miscompares++; $display("[TB] FAIL mid_cleared10: got we=%b addr=%h data=%h expected 1 0a 0", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd12 || bus.rf_data_o !== 32'd0) begin miscompares++; $display("[TB] FAIL mid_blocked12: got we=%b addr=%h data=%h expected 1 0c 0", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o); end
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    vectors++; if (bus.restore_done_o !== 1'b1 || bus.restore_count_o !== 6'd2) begin miscompares++; $display("[TB] FAIL mid_redo_drain: got done=%b count=%0d expected 1 2", bus.restore_done_o, bus.restore_count_o); end
    nextCycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    test_reset();
    test_sweep();
    nextCycle();
    test_short_burst();
    test_commit_during_restore();
    test_commit_on_rise();
    test_back_to_back_repeat();
    test_saturate();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
